// File: rtl/spi_cfg_master.sv
// SPI write-only master for the on-chip register peripheral. Two requesters are
// round-robin arbitrated; each write goes out as one 16-bit CPOL=0 frame.
module spi_cfg_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       done,
    output logic       done_id,
    output logic       busy,
    output logic       sclk,
    output logic       ncs,
    output logic       copi
);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StGap} state_e;

    localparam logic [7:0] HalfM1 = 8'(CLK_DIV - 1);

    state_e      state;
    logic [7:0]  cnt;
    logic [3:0]  bit_cnt;
    logic        sclk_high;
    logic [15:0] frame;
    logic        grant_id;
    logic        last_grant;

    logic        gnt0, gnt1;
    logic [15:0] new_frame;

    // Ready is a Mealy pulse so the acceptance cycle itself is still idle (busy=0).
    always_comb begin
        gnt0       = req0_valid & (~req1_valid | last_grant);
        gnt1       = req1_valid & (~req0_valid | ~last_grant);
        req0_ready = (state == StIdle) & gnt0;
        req1_ready = (state == StIdle) & gnt1;
        new_frame  = gnt0 ? {1'b1, req0_addr, req0_data} : {1'b1, req1_addr, req1_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            cnt        <= 8'd0;
            bit_cnt    <= 4'd0;
            sclk_high  <= 1'b0;
            frame      <= 16'd0;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            ncs        <= 1'b1;
            sclk       <= 1'b0;
            copi       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            done_id    <= 1'b0;
        end else begin
            done    <= 1'b0;
            done_id <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (gnt0 || gnt1) begin
                        frame      <= new_frame;
                        grant_id   <= gnt1;
                        last_grant <= gnt1;
                        busy       <= 1'b1;
                        ncs        <= 1'b0;
                        copi       <= new_frame[15];
                        cnt        <= HalfM1;
                        state      <= StSetup;
                    end
                end
                StSetup: begin
                    if (cnt == 8'd0) begin
                        cnt       <= HalfM1;
                        bit_cnt   <= 4'd15;
                        sclk_high <= 1'b1;
                        sclk      <= 1'b1;
                        copi      <= frame[15];
                        state     <= StShift;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                StShift: begin
                    if (cnt == 8'd0) begin
                        cnt <= HalfM1;
                        if (sclk_high) begin
                            sclk_high <= 1'b0;
                            sclk      <= 1'b0;
                        end else if (bit_cnt == 4'd0) begin
                            state <= StHold;
                        end else begin
                            bit_cnt   <= bit_cnt - 4'd1;
                            sclk_high <= 1'b1;
                            sclk      <= 1'b1;
                            copi      <= frame[bit_cnt - 4'd1];
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                StHold: begin
                    if (cnt == 8'd0) begin
                        cnt   <= HalfM1;
                        ncs   <= 1'b1;
                        copi  <= 1'b0;
                        state <= StGap;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                StGap: begin
                    // done is registered, so raise it one cycle ahead of the GAP end.
                    if (cnt == 8'd1) begin
                        done    <= 1'b1;
                        done_id <= grant_id;
                    end
                    if (cnt == 8'd0) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: peripheral shift-register model, cycle-exact
// waveform model and grant/done logs, at CLK_DIV=4 and CLK_DIV=2.
module tb_spi_cfg_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [6:0] a0 = 7'd0, a1 = 7'd0;
    logic [7:0] d0 = 8'd0, d1 = 8'd0;
    logic       sel = 1'b0;

    logic r0_a, r1_a, done_a, did_a, busy_a, sclk_a, ncs_a, copi_a;
    logic r0_b, r1_b, done_b, did_b, busy_b, sclk_b, ncs_b, copi_b;
    logic m_rdy0, m_rdy1, m_done, m_did, m_busy, m_sclk, m_ncs, m_copi;

    always #5 clk = ~clk;

    spi_cfg_master #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0_a),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1_a),
        .done(done_a), .done_id(did_a), .busy(busy_a),
        .sclk(sclk_a), .ncs(ncs_a), .copi(copi_a)
    );

    spi_cfg_master #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_addr(a0), .req0_data(d0), .req0_ready(r0_b),
        .req1_valid(v1), .req1_addr(a1), .req1_data(d1), .req1_ready(r1_b),
        .done(done_b), .done_id(did_b), .busy(busy_b),
        .sclk(sclk_b), .ncs(ncs_b), .copi(copi_b)
    );

    assign m_rdy0 = sel ? r0_b : r0_a;
    assign m_rdy1 = sel ? r1_b : r1_a;
    assign m_done = sel ? done_b : done_a;
    assign m_did  = sel ? did_b : did_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_sclk = sel ? sclk_b : sclk_a;
    assign m_ncs  = sel ? ncs_b : ncs_a;
    assign m_copi = sel ? copi_b : copi_a;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Peripheral model: shift on falling sclk while selected, commit on ncs rise.
    logic [7:0]  preg [0:4];
    logic [15:0] shreg = 16'd0;
    int          nbits = 0;
    int          sclk_rises = 0;
    int          bad_edges = 0;
    logic        p_ncs = 1'b1, p_sclk = 1'b0;
    logic [15:0] fq[$];

    always @(m_sclk, m_ncs) begin
        if (m_ncs === 1'b1 && p_ncs === 1'b0) begin
            if (nbits == 16) begin
                fq.push_back(shreg);
                if (shreg[15] && shreg[14:8] <= 7'd4) preg[shreg[10:8]] = shreg[7:0];
            end
        end
        if (m_ncs === 1'b0 && p_ncs === 1'b1) nbits = 0;
        if (m_sclk === 1'b0 && p_sclk === 1'b1 && m_ncs === 1'b0) begin
            shreg = {shreg[14:0], m_copi};
            nbits++;
        end
        if (m_sclk === 1'b1 && p_sclk === 1'b0) begin
            sclk_rises++;
            if (m_ncs !== 1'b0) bad_edges++;
        end
        p_ncs  = m_ncs;
        p_sclk = m_sclk;
    end

    // Grant / done logs stamped with a cycle number.
    int cyc = 0;
    int gq[$], gcyc[$], dq[$], dcyc[$];
    int rdy_busy = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (m_rdy0) begin gq.push_back(0); gcyc.push_back(cyc); end
        if (m_rdy1) begin gq.push_back(1); gcyc.push_back(cyc); end
        if ((m_rdy0 || m_rdy1) && m_busy) rdy_busy++;
        if (m_done) begin dq.push_back(int'(m_did)); dcyc.push_back(cyc); end
    end

    task automatic clear_logs();
        gq.delete(); gcyc.delete(); dq.delete(); dcyc.delete(); fq.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic serve(input int n, input bit keep);
        int got = 0;
        bit r0, r1;
        for (int i = 0; i < 3000 && got < n; i++) begin
            @(negedge clk); r0 = m_rdy0; r1 = m_rdy1;
            @(posedge clk); #1;
            if (r0 || r1) begin
                got++;
                if (keep && got == n) begin v0 = 1'b0; v1 = 1'b0; end
                if (!keep && r0) v0 = 1'b0;
                if (!keep && r1) v1 = 1'b0;
            end
        end
        if (got < n) check("serve_timeout", got, n);
    endtask

    task automatic wait_dones(input string tag, input int n);
        for (int i = 0; i < 5000 && dq.size() < n; i++) @(negedge clk);
        check(tag, dq.size(), n);
    endtask

    // Single req0 write with a cycle-exact check of ncs/sclk/copi/busy/done.
    task automatic single(input string tag, input logic [6:0] a, input logic [7:0] d,
                          input int dv);
        logic [15:0] f;
        int lat, errs, k, s;
        logic e_ncs, e_sclk, e_copi;
        f = {1'b1, a, d};
        v0 = 1'b1; a0 = a; d0 = d;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_rdy0) begin lat = i; break; end
        end
        check({tag, "_ready_lat"}, lat, 0);
        if (lat < 0) begin v0 = 1'b0; return; end
        errs = 0;
        for (int t = 0; t < 35 * dv; t++) begin
            @(posedge clk); #1;
            if (t == 0) v0 = 1'b0;
            @(negedge clk);
            if (t < dv) begin
                e_ncs = 1'b0; e_sclk = 1'b0; e_copi = f[15];
            end else if (t < 33 * dv) begin
                s = t - dv; k = 15 - s / (2 * dv);
                e_ncs = 1'b0; e_sclk = (s % (2 * dv)) < dv; e_copi = f[k];
            end else if (t < 34 * dv) begin
                e_ncs = 1'b0; e_sclk = 1'b0; e_copi = f[0];
            end else begin
                e_ncs = 1'b1; e_sclk = 1'b0; e_copi = 1'b0;
            end
            if ({m_ncs, m_sclk, m_copi, m_busy, m_done} !==
                {e_ncs, e_sclk, e_copi, 1'b1, t == 35 * dv - 1}) errs++;
        end
        check({tag, "_wave_errs"}, errs, 0);
        check({tag, "_done_at_end"}, m_done, 1'b1);
        check({tag, "_done_id"}, m_did, 1'b0);
        @(negedge clk);
        check({tag, "_idle_busy"}, m_busy, 1'b0);
        check({tag, "_done_pulse"}, m_done, 1'b0);
        check({tag, "_frame"}, fq.size() > 0 ? fq[0] : 16'hxxxx, f);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) preg[i] = 8'h00;

        // Reset state
        sel = 1'b0;
        do_reset();
        @(negedge clk);
        check("rst_ncs", m_ncs, 1'b1);
        check("rst_sclk", m_sclk, 1'b0);
        check("rst_copi", m_copi, 1'b0);
        check("rst_busy", m_busy, 1'b0);
        check("rst_done", {m_done, m_did}, 2'b00);
        check("rst_ready", {m_rdy0, m_rdy1}, 2'b00);

        // Single write, CLK_DIV=4
        @(posedge clk); #1;
        single("cd4", 7'h00, 8'hA5, 4);
        check("cd4_reg0", preg[0], 8'hA5);

        // Simultaneous requests: req0 wins the first tie after reset
        do_reset();
        a0 = 7'h04; d0 = 8'h80; a1 = 7'h02; d1 = 8'h0F; v0 = 1'b1; v1 = 1'b1;
        serve(2, 1'b0);
        wait_dones("tie_dones", 2);
        if (gq.size() == 2 && dq.size() == 2 && fq.size() == 2) begin
            check("tie_grants", {gq[0][0], gq[1][0]}, 2'b01);
            check("tie_done_ids", {dq[0][0], dq[1][0]}, 2'b01);
            check("tie_frame0", fq[0], 16'h8480);
            check("tie_frame1", fq[1], 16'h820F);
            check("tie_done_lat", dcyc[0] - gcyc[0], 140);
            check("tie_b2b_gap", gcyc[1] - gcyc[0], 141);
        end else begin
            check("tie_log_sizes", {gq.size(), dq.size(), fq.size()}, {32'd2, 32'd2, 32'd2});
        end
        check("tie_regs", {preg[4], preg[2]}, 16'h800F);

        // Both valid continuously: strict alternation
        do_reset();
        a0 = 7'h01; d0 = 8'h11; a1 = 7'h03; d1 = 8'h33; v0 = 1'b1; v1 = 1'b1;
        rdy_busy = 0;
        serve(4, 1'b1);
        wait_dones("rr_dones", 4);
        if (gq.size() == 4) check("rr_grants", {gq[3][0], gq[2][0], gq[1][0], gq[0][0]}, 4'b1010);
        else check("rr_grant_count", gq.size(), 4);
        check("rr_ready_while_busy", rdy_busy, 0);

        // Async reset during bit 7
        do_reset();
        a0 = 7'h00; d0 = 8'hAA; v0 = 1'b1;
        serve(1, 1'b0);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (nbits == 8 && m_sclk === 1'b1 && m_ncs === 1'b0) break;
        end
        check("mid_reached_bit7", {m_copi, m_sclk, m_ncs}, 3'b110);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {m_ncs, m_sclk, m_copi, m_busy}, 4'b1000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        begin
            int rises0, dones0;
            rises0 = sclk_rises; dones0 = dq.size();
            repeat (200) @(negedge clk);
            check("mid_no_sclk", sclk_rises - rises0, 0);
            check("mid_no_done", dq.size() - dones0, 0);
            check("mid_no_frame", fq.size(), 0);
            check("mid_reg0_kept", preg[0], 8'hA5);
        end

        // Dropped req1 while busy with req0; unfiltered address 0x05
        do_reset();
        a0 = 7'h05; d0 = 8'h5A; v0 = 1'b1;
        serve(1, 1'b0);
        repeat (20) @(posedge clk);
        #1 a1 = 7'h02; d1 = 8'h77; v1 = 1'b1;
        repeat (60) @(posedge clk);
        #1 v1 = 1'b0;
        wait_dones("drop_done", 1);
        repeat (300) @(negedge clk);
        check("drop_grants", gq.size(), 1);
        check("drop_frames", fq.size(), 1);
        if (fq.size() > 0) check("drop_frame0", fq[0], 16'h855A);
        check("drop_idle", {m_ncs, m_busy}, 2'b10);
        check("drop_reg2_kept", preg[2], 8'h0F);

        // Boundary: CLK_DIV=2, all-ones frame
        sel = 1'b1;
        do_reset();
        single("cd2", 7'h7F, 8'hFF, 2);
        if (dq.size() > 0 && gcyc.size() > 0) check("cd2_done_lat", dcyc[0] - gcyc[0], 70);
        else check("cd2_logs", dq.size(), 1);

        check("no_edge_ncs_high", bad_edges, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
